// File: rtl/shift_seq.sv
// shift_seq: iterative 16-bit shifter, one radix-3 level (stride 1, 3, 9) per cycle,
// feeding a 16-wide array of 3:1 muxes; valid/ready on both sides.
module shift_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [3:0]       Shift_Val,
  input  logic [1:0]       Mode,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             Busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] k, k_n, mode, mode_n, dk;
  logic [5:0] dig, dig_n;
  logic [WIDTH-1:0] data, data_n, c1, c2, sel;
  logic [3:0] s;
  logic [3*WIDTH-1:0] cand;
  // Shift amounts up to 18 are legal here so the unused stride-9 candidate stays defined.
  function automatic logic [15:0] shf(input logic [15:0] x, input logic [4:0] n, input logic [1:0] m);
    return m == 2'b00 ? 16'({16'h0, x} << n) :
           m == 2'b01 ? 16'({{16{x[15]}}, x} >> n) :
           m == 2'b10 ? 16'({x, x} >> n[3:0]) :
                        16'({16'h0, x} >> n);
  endfunction
  assign s  = k == 2'd0 ? 4'd1 : k == 2'd1 ? 4'd3 : 4'd9;
  assign dk = k == 2'd0 ? dig[1:0] : k == 2'd1 ? dig[3:2] : dig[5:4];
  assign c1 = shf(data, {1'b0, s}, mode);
  assign c2 = shf(data, {s, 1'b0}, mode);
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    assign cand[3*i +: 3] = {c2[i], c1[i], data[i]};
    assign sel[i] = dk == 2'd2 ? cand[3*i+2] : dk == 2'd1 ? cand[3*i+1] : cand[3*i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k     <= 2'd0;
      data  <= '0;
      mode  <= 2'd0;
      dig   <= 6'd0;
    end else begin
      state <= state_n;
      k     <= k_n;
      data  <= data_n;
      mode  <= mode_n;
      dig   <= dig_n;
    end
  always_comb begin
    state_n = state;
    k_n     = k;
    data_n  = data;
    mode_n  = mode;
    dig_n   = dig;
    if (state == IDLE && In_valid) begin
      state_n = SHIFT;
      k_n     = 2'd0;
      data_n  = Shift_In;
      mode_n  = Mode;
      dig_n   = {2'(Shift_Val / 4'd9), 2'((Shift_Val / 4'd3) % 4'd3), 2'(Shift_Val % 4'd3)};
    end else if (state == SHIFT) begin
      data_n  = sel;
      k_n     = k == 2'd2 ? 2'd0 : 2'(k + 2'd1);
      state_n = k == 2'd2 ? DONE : SHIFT;
    end else if (state == DONE && Out_ready) begin
      state_n = IDLE;
    end
  end
  assign In_ready  = state == IDLE;
  assign Out_valid = state == DONE;
  assign Busy      = state != IDLE;
  assign Shift_Out = data;
endmodule
